// File: rtl/paicore_loopback_arb.sv
// paicore_loopback_arb: round-robin accept across CHANNEL handshake inputs,
// looping each word back out on its own channel through an order-preserving FIFO.
module paicore_loopback_arb #(
  parameter int CHANNEL = 16,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [31:0]                 frame_num_max,
  input  logic [CHANNEL-1:0]          in_req,
  input  logic [CHANNEL*WORD_W-1:0]   in_data,
  output logic [CHANNEL-1:0]          in_ack,
  output logic [CHANNEL-1:0]          out_req,
  output logic [CHANNEL*WORD_W-1:0]   out_data,
  input  logic [CHANNEL-1:0]          out_ack,
  output logic [$clog2(DEPTH):0]      level,
  output logic [31:0]                 in_cnt,
  output logic [31:0]                 out_cnt,
  output logic                        done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHANNEL);
  logic [CW+WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q, level_d;
  logic [CW-1:0] rr_q, grant, head_ch;
  logic [CW:0] cand;
  logic [WORD_W-1:0] head_word;
  logic [31:0] in_cnt_q, out_cnt_q, out_cnt_d;
  logic found, push, pop, nonempty, en_q, clear, done_q;
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      cand = {1'b0, rr_q} + (CW+1)'(k);
      cand = (cand >= (CW+1)'(CHANNEL)) ? cand - (CW+1)'(CHANNEL) : cand;
      if (!found && in_req[cand[CW-1:0]]) begin
        found = 1'b1;
        grant = cand[CW-1:0];
      end
    end
  end
  // A full FIFO refuses the push even when the head pops in the same cycle.
  assign push      = aresetn & enable & found & (level_q != (AW+1)'(DEPTH));
  assign nonempty  = level_q != '0;
  assign {head_ch, head_word} = mem_q[rd_q];
  assign pop       = nonempty & out_ack[head_ch];
  assign clear     = enable & ~en_q;
  assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
  assign out_cnt_d = (clear ? '0 : out_cnt_q) + 32'(pop);
  assign in_ack    = push ? CHANNEL'(1) << grant : '0;
  assign out_req   = nonempty ? CHANNEL'(1) << head_ch : '0;
  assign out_data  = nonempty ? (CHANNEL*WORD_W)'(head_word) << (head_ch * WORD_W) : '0;
  assign level     = level_q;
  assign in_cnt    = in_cnt_q;
  assign out_cnt   = out_cnt_q;
  assign done      = done_q;
  always_ff @(posedge aclk)
    if (push) mem_q[wr_q] <= {grant, in_data[grant*WORD_W +: WORD_W]};
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      en_q      <= 1'b0;
      level_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      rr_q      <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      en_q      <= enable;
      level_q   <= level_d;
      wr_q      <= wr_q + AW'(push);
      rd_q      <= rd_q + AW'(pop);
      rr_q      <= push ? ((grant == CW'(CHANNEL-1)) ? '0 : grant + 1'b1) : rr_q;
      in_cnt_q  <= (clear ? '0 : in_cnt_q) + 32'(push);
      out_cnt_q <= out_cnt_d;
      done_q    <= (done_q & ~clear) | ((frame_num_max != '0) & (out_cnt_d == frame_num_max));
    end
endmodule

// File: tb/tb_paicore_loopback_arb.sv
// tb_paicore_loopback_arb: random and directed stimulus against a queue-based
// reference of the loopback arbiter (4 channels, 16-entry FIFO).
module tb_paicore_loopback_arb;
  localparam int CH = 4;
  localparam int W  = 32;
  localparam int D  = 16;
  logic aclk, aresetn, enable;
  logic [31:0] frame_num_max;
  logic [CH-1:0] in_req, in_ack, out_req, out_ack;
  logic [CH*W-1:0] in_data, out_data;
  logic [$clog2(D):0] level;
  logic [31:0] in_cnt, out_cnt;
  logic done;
  int n_tests, n_fail;
  int qc[$];
  logic [W-1:0] qw[$];
  int m_rr;
  logic m_enp, m_done;
  logic [31:0] m_in, m_out;
  paicore_loopback_arb #(.CHANNEL(CH), .WORD_W(W), .DEPTH(D)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .frame_num_max(frame_num_max),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .level(level), .in_cnt(in_cnt), .out_cnt(out_cnt), .done(done)
  );
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: drive at negedge, compare against the model, then advance the model past the posedge.
  task automatic cycle(input logic en, input logic [3:0] req, input logic [3:0] oack);
    logic [3:0] eack, ereq;
    logic [127:0] edata;
    logic clr, po;
    int g;
    @(negedge aclk);
    enable = en;
    in_req = req;
    out_ack = oack;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    eack = '0;
    g = -1;
    if (en && qc.size() < D)
      for (int k = 0; k < CH; k++) begin
        int c = (m_rr + k) % CH;
        if (g < 0 && req[c]) g = c;
      end
    if (g >= 0) eack[g] = 1'b1;
    ereq = '0;
    edata = '0;
    if (qc.size() > 0) begin
      ereq[qc[0]] = 1'b1;
      edata[qc[0]*W +: W] = qw[0];
    end
    check("in_ack", in_ack, eack);
    check("out_req", out_req, ereq);
    check("out_data", out_data, edata);
    check("level", level, qc.size());
    check("in_cnt", in_cnt, m_in);
    check("out_cnt", out_cnt, m_out);
    check("done", done, m_done);
    clr = en && !m_enp;
    m_enp = en;
    po = qc.size() > 0 && oack[qc[0]];
    if (po) begin
      void'(qc.pop_front());
      void'(qw.pop_front());
    end
    if (g >= 0) begin
      qc.push_back(g);
      qw.push_back(in_data[g*W +: W]);
      m_rr = (g + 1) % CH;
    end
    m_in  = (clr ? 32'd0 : m_in) + 32'(g >= 0);
    m_out = (clr ? 32'd0 : m_out) + 32'(po);
    m_done = (m_done && !clr) || (frame_num_max != 0 && m_out == frame_num_max);
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    check("rst_in_ack", in_ack, 0);
    check("rst_out_req", out_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_in_cnt", in_cnt, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_done", done, 0);
    qc.delete();
    qw.delete();
    m_rr = 0;
    m_enp = 1'b0;
    m_in = '0;
    m_out = '0;
    m_done = 1'b0;
    enable = 1'b0;
    in_req = '0;
    out_ack = '0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    aresetn = 1'b0;
    enable = 1'b1;
    in_req = 4'hF;
    out_ack = 4'hF;
    in_data = '0;
    frame_num_max = 32'd0;
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'hF, 4'hF);
    for (int i = 0; i < 40 && qc.size() > 0; i++) cycle(1'b1, 4'h0, 4'hF);
    for (int i = 0; i < 20; i++) cycle(1'b1, 4'hF, 4'h0);
    cycle(1'b1, 4'hF, 4'h0);
    check("sat_level", level, D);
    check("sat_in_ack", in_ack, 0);
    cycle(1'b1, 4'hF, 4'hF);
    check("full_level", level, D);
    check("full_no_push", in_ack, 0);
    cycle(1'b1, 4'h0, 4'h0);
    check("full_pop_level", level, D - 1);
    for (int i = 0; i < 40 && qc.size() > 0; i++) cycle(1'b1, 4'h0, 4'hF);
    check("drained", qc.size(), 0);
    frame_num_max = 32'd5;
    cycle(1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 30 && m_out != 5; i++)
      cycle(1'b1, (m_in < 5) ? 4'($urandom_range(1, 15)) : 4'h0, 4'hF);
    cycle(1'b1, 4'h0, 4'h0);
    check("done_set", done, 1);
    check("done_out_cnt", out_cnt, 5);
    cycle(1'b0, 4'h0, 4'h0);
    check("done_sticky", done, 1);
    cycle(1'b1, 4'h0, 4'h0);
    cycle(1'b1, 4'h0, 4'h0);
    check("clr_done", done, 0);
    check("clr_in_cnt", in_cnt, 0);
    check("clr_out_cnt", out_cnt, 0);
    frame_num_max = 32'd0;
    cycle(1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 600 && m_out != 100; i++)
      cycle(1'b1, (m_in < 100) ? 4'($urandom_range(1, 15)) : 4'h0, 4'($urandom));
    cycle(1'b1, 4'h0, 4'h0);
    check("fnm0_out_cnt", out_cnt, 100);
    check("fnm0_done", done, 0);
    for (int i = 0; i < 40 && qc.size() > 0; i++) cycle(1'b1, 4'h0, 4'hF);
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'($urandom_range(1, 15)), 4'h0);
    cycle(1'b1, 4'hF, 4'h0);
    check("pre_rst_level", level, 7);
    do_reset();
    cycle(1'b1, 4'h0, 4'hF);
    cycle(1'b1, 4'h0, 4'hF);
    check("post_rst_level", level, 0);
    check("post_rst_out_req", out_req, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) frame_num_max = $urandom_range(0, 20);
      cycle($urandom_range(0, 15) != 0, 4'($urandom), 4'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
